// File: rtl/button_events.sv
// ============================================================================
// Module   : button_events
// Brief    : Push-button conditioner: 2-FF sync, debounce, press/release
//            pulses and hold-to-auto-repeat. Macro BUTTON_EVENTS_REPEAT_EN
//            enables the hold FSM / REPEAT output (tied low otherwise).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_events #(
    parameter int N_BTN         = 3,
    parameter int ACTIVE_LOW    = 1,
    parameter int DEB_CYCLES    = 50000,
    parameter int REPEAT_DELAY  = 500000,
    parameter int REPEAT_PERIOD = 125000,
    parameter int CNT_W         = 20
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_BTN-1:0] BTN_IN,
    output logic [N_BTN-1:0] BTN_HELD,
    output logic [N_BTN-1:0] PRESS,
    output logic [N_BTN-1:0] RELEASE,
    output logic [N_BTN-1:0] REPEAT,
    output logic             ANY_PRESS
);

    localparam logic             c_REL_LVL  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    // Elaboration-time guard against configurations the counters cannot hold
    if (DEB_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_DELAY < 1 ||
        longint'(DEB_CYCLES)    >= (longint'(1) << CNT_W) ||
        longint'(REPEAT_DELAY)  >= (longint'(1) << CNT_W) ||
        longint'(REPEAT_PERIOD) >= (longint'(1) << CNT_W)) begin : g_cfg_error
        $error("button_events: invalid parameter set");
    end

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] r_stable;
    logic [CNT_W-1:0] r_deb_cnt [N_BTN];

    logic [N_BTN-1:0] w_lvl;
    logic [N_BTN-1:0] w_cnt_last;
    logic [N_BTN-1:0] w_hit;
    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] w_fall;

    // Normalise to pressed = 1 regardless of pin polarity
    assign w_lvl  = r_sync2 ^ {N_BTN{c_REL_LVL}};
    assign w_hit  = w_cnt_last & (w_lvl ^ r_stable);
    assign w_rise = w_hit & ~r_stable;
    assign w_fall = w_hit & r_stable;

    always_comb begin
        w_cnt_last = '0;
        for (int i = 0; i < N_BTN; i++) begin
            w_cnt_last[i] = (r_deb_cnt[i] == c_DEB_LAST);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1   <= {N_BTN{c_REL_LVL}};
            r_sync2   <= {N_BTN{c_REL_LVL}};
            r_stable  <= '0;
            PRESS     <= '0;
            RELEASE   <= '0;
            ANY_PRESS <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_sync1   <= BTN_IN;
            r_sync2   <= r_sync1;
            r_stable  <= r_stable ^ w_hit;
            PRESS     <= w_rise;
            RELEASE   <= w_fall;
            ANY_PRESS <= |w_rise;
            for (int i = 0; i < N_BTN; i++) begin
                if (w_lvl[i] == r_stable[i] || w_hit[i]) begin
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + c_ONE;
                end
            end
        end
    end

    assign BTN_HELD = r_stable;

`ifdef BUTTON_EVENTS_REPEAT_EN
    localparam logic [CNT_W-1:0] c_DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] c_PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DELAY     = 2'd1,
        ST_REPEATING = 2'd2
    } hold_state_t;

    hold_state_t      r_state    [N_BTN];
    logic [CNT_W-1:0] r_hold_cnt [N_BTN];

    // Release takes priority so a REPEAT can never share a cycle with RELEASE
    always_ff @(posedge CLK) begin
        if (RST) begin
            REPEAT <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_state[i]    <= ST_IDLE;
                r_hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                REPEAT[i] <= 1'b0;
                if (w_fall[i]) begin
                    r_state[i]    <= ST_IDLE;
                    r_hold_cnt[i] <= '0;
                end else if (w_rise[i]) begin
                    r_state[i]    <= ST_DELAY;
                    r_hold_cnt[i] <= '0;
                end else begin
                    case (r_state[i])
                        ST_DELAY: begin
                            if (r_hold_cnt[i] == c_DLY_LAST) begin
                                REPEAT[i]     <= 1'b1;
                                r_hold_cnt[i] <= '0;
                                r_state[i]    <= ST_REPEATING;
                            end else begin
                                r_hold_cnt[i] <= r_hold_cnt[i] + c_ONE;
                            end
                        end
                        ST_REPEATING: begin
                            if (r_hold_cnt[i] == c_PER_LAST) begin
                                REPEAT[i]     <= 1'b1;
                                r_hold_cnt[i] <= '0;
                            end else begin
                                r_hold_cnt[i] <= r_hold_cnt[i] + c_ONE;
                            end
                        end
                        default: begin
                            r_state[i]    <= ST_IDLE;
                            r_hold_cnt[i] <= '0;
                        end
                    endcase
                end
            end
        end
    end
`else
    assign REPEAT = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_button_events.sv
// ============================================================================
// Module   : tb_button_events
// Brief    : Directed self-checking bench for button_events (DEB_CYCLES=4,
//            REPEAT_DELAY=10, REPEAT_PERIOD=3); honours BUTTON_EVENTS_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_events;

    localparam int c_N = 3;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic [c_N-1:0] BTN_IN = 3'b111;
    logic [c_N-1:0] BTN_HELD;
    logic [c_N-1:0] PRESS;
    logic [c_N-1:0] RELEASE;
    logic [c_N-1:0] REPEAT;
    logic           ANY_PRESS;

    int n_total = 0;
    int n_bad   = 0;

    button_events #(
        .N_BTN         (c_N),
        .ACTIVE_LOW    (1),
        .DEB_CYCLES    (4),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (3),
        .CNT_W         (8)
    ) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .BTN_IN    (BTN_IN),
        .BTN_HELD  (BTN_HELD),
        .PRESS     (PRESS),
        .RELEASE   (RELEASE),
        .REPEAT    (REPEAT),
        .ANY_PRESS (ANY_PRESS)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; all samples are taken 1ns after posedge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [2:0] held, input logic [2:0] prs,
                             input logic [2:0] rel, input logic [2:0] rep);
        check({tag, " held"}, 32'(BTN_HELD), 32'(held));
        check({tag, " press"}, 32'(PRESS), 32'(prs));
        check({tag, " release"}, 32'(RELEASE), 32'(rel));
        check({tag, " repeat"}, 32'(REPEAT), 32'(rep));
        check({tag, " any"}, 32'(ANY_PRESS), 32'(|prs));
    endtask

    initial begin
        logic [2:0] exp_rep;

        // Reset with all buttons released
        repeat (3) tick();
        check_all("reset", 3'b000, 3'b000, 3'b000, 3'b000);
        RST = 1'b0;
        for (int e = 0; e < 50; e++) begin
            tick();
            check_all($sformatf("idle e%0d", e), 3'b000, 3'b000, 3'b000, 3'b000);
        end

        // Clean press then release on channel 0
        BTN_IN[0] = 1'b0;
        for (int e = 0; e < 9; e++) begin
            tick();
            check_all($sformatf("press0 e%0d", e), (e >= 5) ? 3'b001 : 3'b000,
                      (e == 5) ? 3'b001 : 3'b000, 3'b000, 3'b000);
        end
        BTN_IN[0] = 1'b1;
        for (int e = 0; e < 9; e++) begin
            tick();
            check_all($sformatf("rel0 e%0d", e), (e < 5) ? 3'b001 : 3'b000,
                      3'b000, (e == 5) ? 3'b001 : 3'b000, 3'b000);
        end

        // Glitches of 3 low cycles separated by 1 high cycle never qualify
        for (int g = 0; g < 4; g++) begin
            for (int e = 0; e < 4; e++) begin
                BTN_IN[1] = (e == 3);
                tick();
                check_all($sformatf("glitch g%0d e%0d", g, e), 3'b000, 3'b000, 3'b000, 3'b000);
            end
        end
        for (int e = 0; e < 10; e++) begin
            tick();
            check_all($sformatf("glitch tail e%0d", e), 3'b000, 3'b000, 3'b000, 3'b000);
        end

        // Auto-repeat on channel 2: PRESS at 5, REPEAT at 15,18,...,48, RELEASE at 51
        BTN_IN[2] = 1'b0;
        for (int e = 0; e < 60; e++) begin
            tick();
`ifdef BUTTON_EVENTS_REPEAT_EN
            exp_rep = (e >= 15 && e < 51 && ((e - 15) % 3) == 0) ? 3'b100 : 3'b000;
`else
            exp_rep = 3'b000;
`endif
            check_all($sformatf("hold2 e%0d", e), (e >= 5 && e < 51) ? 3'b100 : 3'b000,
                      (e == 5) ? 3'b100 : 3'b000, (e == 51) ? 3'b100 : 3'b000, exp_rep);
            if (e == 45) BTN_IN[2] = 1'b1;
        end

        // All three pressed together, then reset while still in the delay phase
        BTN_IN = 3'b000;
        for (int e = 0; e < 8; e++) begin
            tick();
            check_all($sformatf("sim e%0d", e), (e >= 5) ? 3'b111 : 3'b000,
                      (e == 5) ? 3'b111 : 3'b000, 3'b000, 3'b000);
        end
        RST = 1'b1;
        tick();
        check_all("midhold rst0", 3'b000, 3'b000, 3'b000, 3'b000);
        tick();
        check_all("midhold rst1", 3'b000, 3'b000, 3'b000, 3'b000);
        RST = 1'b0;
        for (int e = 1; e < 10; e++) begin
            tick();
            check_all($sformatf("repress e%0d", e), (e >= 6) ? 3'b111 : 3'b000,
                      (e == 6) ? 3'b111 : 3'b000, 3'b000, 3'b000);
        end
        BTN_IN = 3'b111;
        for (int e = 0; e < 9; e++) begin
            tick();
            check_all($sformatf("relall e%0d", e), (e < 5) ? 3'b111 : 3'b000,
                      3'b000, (e == 5) ? 3'b111 : 3'b000, 3'b000);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
